// File: rtl/alu_8bit.sv
// -----------------------------------------------------------------------------
// alu_8bit
//   Execute-stage ALU: eight arithmetic/logic/shift operations on two 8-bit
//   operands, selected by a 3-bit opcode. The combinational result and flags
//   are captured on the rising clock edge, so every operation has a fixed
//   one-cycle latency. A new operation may be issued every cycle.
//
// Ports
//   clk_i    in   1  system clock, rising-edge active
//   rst_ni   in   1  asynchronous, active-low reset
//   a_i      in   8  operand A
//   b_i      in   8  operand B (ignored by NOT, SHL, SHR)
//   op_i     in   3  operation select
//   alu_o    out  8  registered result
//   carry_o  out  1  registered carry / borrow / shift-out flag
//   zero_o   out  1  registered flag, 1 when alu_o == 8'h00
//
// Reset values: alu_o = 8'h00, carry_o = 1'b0, zero_o = 1'b1 (consistent with
// a zero result).
// -----------------------------------------------------------------------------
module alu_8bit (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic [2:0] op_i,
  output logic [7:0] alu_o,
  output logic       carry_o,
  output logic       zero_o
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  // Zero-detect helper shared by the flag path.
  function automatic logic is_zero(input logic [7:0] value);
    is_zero = (value == 8'h00);
  endfunction

  logic [8:0] wide_s;    // 9-bit working value: {carry, result}
  logic [7:0] res_s;
  logic       carry_s;
  logic       zero_s;

  logic [7:0] alu_r;
  logic       carry_r;
  logic       zero_r;

  // Combinational operation select producing next result and carry.
  always_comb begin
    wide_s = 9'h000;
    case (op_i)
      OP_ADD: wide_s = {1'b0, a_i} + {1'b0, b_i};
      // Zero-extended subtraction: bit 8 is set exactly when a_i < b_i.
      OP_SUB: wide_s = {1'b0, a_i} - {1'b0, b_i};
      OP_AND: wide_s = {1'b0, a_i & b_i};
      OP_OR:  wide_s = {1'b0, a_i | b_i};
      OP_XOR: wide_s = {1'b0, a_i ^ b_i};
      OP_NOT: wide_s = {1'b0, ~a_i};
      // Shift-out bit lands in bit 8 so carry extraction is uniform.
      OP_SHL: wide_s = {a_i[7], a_i[6:0], 1'b0};
      OP_SHR: wide_s = {a_i[0], 1'b0, a_i[7:1]};
      default: wide_s = 9'h000;
    endcase
  end

  assign res_s   = wide_s[7:0];
  assign carry_s = wide_s[8];
  assign zero_s  = is_zero(wide_s[7:0]);

  // Output registers with asynchronous active-low clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alu_r   <= 8'h00;
      carry_r <= 1'b0;
      zero_r  <= 1'b1;
    end else begin
      alu_r   <= res_s;
      carry_r <= carry_s;
      zero_r  <= zero_s;
    end
  end

  assign alu_o   = alu_r;
  assign carry_o = carry_r;
  assign zero_o  = zero_r;

endmodule

// File: tb/tb_alu_8bit.sv
// -----------------------------------------------------------------------------
// tb_alu_8bit
//   Directed, self-checking bench for alu_8bit. Each task drives one scenario
//   and compares {alu_o, carry_o, zero_o} against hand-computed values.
//   Inputs change 1 time unit after the rising edge; outputs are sampled at
//   that same point (after the edge) or between edges.
// -----------------------------------------------------------------------------
module tb_alu_8bit;

  logic       clk_i;
  logic       rst_ni;
  logic [7:0] a_i;
  logic [7:0] b_i;
  logic [2:0] op_i;
  logic [7:0] alu_o;
  logic       carry_o;
  logic       zero_o;

  int checks_total;
  int checks_passed;

  alu_8bit dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .a_i     (a_i),
    .b_i     (b_i),
    .op_i    (op_i),
    .alu_o   (alu_o),
    .carry_o (carry_o),
    .zero_o  (zero_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Drive one operation, wait for the capturing edge, settle 1 unit past it.
  task automatic apply(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    op_i = op;
    a_i  = a;
    b_i  = b;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset;
    apply(3'b000, 8'h10, 8'h20);
    checks_total++;
    if ({alu_o, carry_o, zero_o} !== {8'h30, 1'b0, 1'b0})
      $display("FAIL pre_reset_add: got %h/%b/%b want 30/0/0", alu_o, carry_o, zero_o);
    else checks_passed++;
    // Assert reset between edges with random inputs; outputs clear without an edge.
    a_i    = 8'($urandom);
    b_i    = 8'($urandom);
    op_i   = 3'($urandom);
    #1;
    rst_ni = 1'b0;
    #1;
    checks_total++;
    if ({alu_o, carry_o, zero_o} !== {8'h00, 1'b0, 1'b1})
      $display("FAIL reset_async: got %h/%b/%b want 00/0/1", alu_o, carry_o, zero_o);
    else checks_passed++;
    // Reset holds across clock edges.
    @(posedge clk_i);
    #1;
    checks_total++;
    if ({alu_o, carry_o, zero_o} !== {8'h00, 1'b0, 1'b1})
      $display("FAIL reset_hold: got %h/%b/%b want 00/0/1", alu_o, carry_o, zero_o);
    else checks_passed++;
    // Release mid-cycle; nothing changes until the next edge.
    op_i   = 3'b000;
    a_i    = 8'h01;
    b_i    = 8'h01;
    rst_ni = 1'b1;
    #2;
    checks_total++;
    if ({alu_o, carry_o, zero_o} !== {8'h00, 1'b0, 1'b1})
      $display("FAIL reset_release_wait: got %h/%b/%b want 00/0/1", alu_o, carry_o, zero_o);
    else checks_passed++;
    @(posedge clk_i);
    #1;
    checks_total++;
    if ({alu_o, carry_o, zero_o} !== {8'h02, 1'b0, 1'b0})
      $display("FAIL reset_first_result: got %h/%b/%b want 02/0/0", alu_o, carry_o, zero_o);
    else checks_passed++;
  endtask

  task automatic test_add_sub;
    apply(3'b000, 8'hAA, 8'hAA);
    checks_total++;
    if ({alu_o, carry_o, zero_o} !== {8'h54, 1'b1, 1'b0})
      $display("FAIL add_aa_aa: got %h/%b/%b want 54/1/0", alu_o, carry_o, zero_o);
    else checks_passed++;
    apply(3'b000, 8'h80, 8'h80);
    checks_total++;
    if ({alu_o, carry_o, zero_o} !== {8'h00, 1'b1, 1'b1})
      $display("FAIL add_wrap_zero: got %h/%b/%b want 00/1/1", alu_o, carry_o, zero_o);
    else checks_passed++;
    apply(3'b001, 8'hAA, 8'hAA);
    checks_total++;
    if ({alu_o, carry_o, zero_o} !== {8'h00, 1'b0, 1'b1})
      $display("FAIL sub_aa_aa: got %h/%b/%b want 00/0/1", alu_o, carry_o, zero_o);
    else checks_passed++;
    apply(3'b001, 8'h01, 8'h02);
    checks_total++;
    if ({alu_o, carry_o, zero_o} !== {8'hFF, 1'b1, 1'b0})
      $display("FAIL sub_borrow: got %h/%b/%b want FF/1/0", alu_o, carry_o, zero_o);
    else checks_passed++;
    apply(3'b001, 8'h50, 8'h21);
    checks_total++;
    if ({alu_o, carry_o, zero_o} !== {8'h2F, 1'b0, 1'b0})
      $display("FAIL sub_plain: got %h/%b/%b want 2F/0/0", alu_o, carry_o, zero_o);
    else checks_passed++;
  endtask

  task automatic test_logic;
    apply(3'b010, 8'hAA, 8'hAA);
    checks_total++;
    if ({alu_o, carry_o, zero_o} !== {8'hAA, 1'b0, 1'b0})
      $display("FAIL and_aa: got %h/%b/%b want AA/0/0", alu_o, carry_o, zero_o);
    else checks_passed++;
    apply(3'b011, 8'hAA, 8'hAA);
    checks_total++;
    if ({alu_o, carry_o, zero_o} !== {8'hAA, 1'b0, 1'b0})
      $display("FAIL or_aa: got %h/%b/%b want AA/0/0", alu_o, carry_o, zero_o);
    else checks_passed++;
    apply(3'b100, 8'hAA, 8'hAA);
    checks_total++;
    if ({alu_o, carry_o, zero_o} !== {8'h00, 1'b0, 1'b1})
      $display("FAIL xor_aa: got %h/%b/%b want 00/0/1", alu_o, carry_o, zero_o);
    else checks_passed++;
    apply(3'b101, 8'hAA, 8'hAA);
    checks_total++;
    if ({alu_o, carry_o, zero_o} !== {8'h55, 1'b0, 1'b0})
      $display("FAIL not_aa: got %h/%b/%b want 55/0/0", alu_o, carry_o, zero_o);
    else checks_passed++;
    // Distinct operands separate AND from OR and check NOT ignores b_i.
    apply(3'b010, 8'hF0, 8'h3C);
    checks_total++;
    if ({alu_o, carry_o, zero_o} !== {8'h30, 1'b0, 1'b0})
      $display("FAIL and_f0_3c: got %h/%b/%b want 30/0/0", alu_o, carry_o, zero_o);
    else checks_passed++;
    apply(3'b011, 8'hF0, 8'h0C);
    checks_total++;
    if ({alu_o, carry_o, zero_o} !== {8'hFC, 1'b0, 1'b0})
      $display("FAIL or_f0_0c: got %h/%b/%b want FC/0/0", alu_o, carry_o, zero_o);
    else checks_passed++;
    apply(3'b101, 8'hFF, 8'h12);
    checks_total++;
    if ({alu_o, carry_o, zero_o} !== {8'h00, 1'b0, 1'b1})
      $display("FAIL not_ff: got %h/%b/%b want 00/0/1", alu_o, carry_o, zero_o);
    else checks_passed++;
  endtask

  task automatic test_shift;
    apply(3'b110, 8'hAA, 8'h00);
    checks_total++;
    if ({alu_o, carry_o, zero_o} !== {8'h54, 1'b1, 1'b0})
      $display("FAIL shl_aa: got %h/%b/%b want 54/1/0", alu_o, carry_o, zero_o);
    else checks_passed++;
    apply(3'b111, 8'hFF, 8'hFF);
    checks_total++;
    if ({alu_o, carry_o, zero_o} !== {8'h7F, 1'b1, 1'b0})
      $display("FAIL shr_ff: got %h/%b/%b want 7F/1/0", alu_o, carry_o, zero_o);
    else checks_passed++;
    apply(3'b111, 8'h02, 8'h00);
    checks_total++;
    if ({alu_o, carry_o, zero_o} !== {8'h01, 1'b0, 1'b0})
      $display("FAIL shr_02: got %h/%b/%b want 01/0/0", alu_o, carry_o, zero_o);
    else checks_passed++;
    apply(3'b110, 8'h80, 8'h00);
    checks_total++;
    if ({alu_o, carry_o, zero_o} !== {8'h00, 1'b1, 1'b1})
      $display("FAIL shl_80: got %h/%b/%b want 00/1/1", alu_o, carry_o, zero_o);
    else checks_passed++;
  endtask

  // Every opcode in consecutive cycles, a=96 b=3C; results hand-computed.
  task automatic test_back_to_back;
    logic [10:0] exp_tbl [8];
    exp_tbl[0] = {8'hD2, 1'b0, 1'b0};  // ADD 96+3C
    exp_tbl[1] = {8'h5A, 1'b0, 1'b0};  // SUB 96-3C
    exp_tbl[2] = {8'h14, 1'b0, 1'b0};  // AND
    exp_tbl[3] = {8'hBE, 1'b0, 1'b0};  // OR
    exp_tbl[4] = {8'hAA, 1'b0, 1'b0};  // XOR
    exp_tbl[5] = {8'h69, 1'b0, 1'b0};  // NOT
    exp_tbl[6] = {8'h2C, 1'b1, 1'b0};  // SHL
    exp_tbl[7] = {8'h4B, 1'b0, 1'b0};  // SHR
    for (int i = 0; i < 8; i++) begin
      op_i = 3'(i);
      a_i  = 8'h96;
      b_i  = 8'h3C;
      // Before the edge the previous result must still be held.
      #3;
      if (i > 0) begin
        checks_total++;
        if ({alu_o, carry_o, zero_o} !== exp_tbl[i-1])
          $display("FAIL b2b_hold_op%0d: got %h/%b/%b want %h", i, alu_o, carry_o, zero_o, exp_tbl[i-1]);
        else checks_passed++;
      end
      @(posedge clk_i);
      #1;
      checks_total++;
      if ({alu_o, carry_o, zero_o} !== exp_tbl[i])
        $display("FAIL b2b_op%0d: got %h/%b/%b want %h", i, alu_o, carry_o, zero_o, exp_tbl[i]);
      else checks_passed++;
    end
  endtask

  task automatic test_reset_midstream;
    // Outputs currently hold SHR result 4B; issue ADD FF+01 and reset before its edge.
    op_i = 3'b000;
    a_i  = 8'hFF;
    b_i  = 8'h01;
    #3;
    rst_ni = 1'b0;
    #1;
    checks_total++;
    if ({alu_o, carry_o, zero_o} !== {8'h00, 1'b0, 1'b1})
      $display("FAIL mid_reset_clear: got %h/%b/%b want 00/0/1", alu_o, carry_o, zero_o);
    else checks_passed++;
    @(posedge clk_i);
    #1;
    // The ADD carry (1) must not leak through the edge while in reset.
    checks_total++;
    if ({alu_o, carry_o, zero_o} !== {8'h00, 1'b0, 1'b1})
      $display("FAIL mid_reset_noleak: got %h/%b/%b want 00/0/1", alu_o, carry_o, zero_o);
    else checks_passed++;
    op_i   = 3'b001;
    a_i    = 8'h01;
    b_i    = 8'h02;
    rst_ni = 1'b1;
    #2;
    checks_total++;
    if ({alu_o, carry_o, zero_o} !== {8'h00, 1'b0, 1'b1})
      $display("FAIL mid_release_wait: got %h/%b/%b want 00/0/1", alu_o, carry_o, zero_o);
    else checks_passed++;
    @(posedge clk_i);
    #1;
    checks_total++;
    if ({alu_o, carry_o, zero_o} !== {8'hFF, 1'b1, 1'b0})
      $display("FAIL mid_first_result: got %h/%b/%b want FF/1/0", alu_o, carry_o, zero_o);
    else checks_passed++;
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    rst_ni = 1'b1;
    op_i   = 3'b000;
    a_i    = 8'h00;
    b_i    = 8'h00;
    #1;
    test_reset;
    test_add_sub;
    test_logic;
    test_shift;
    test_back_to_back;
    test_reset_midstream;
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
